// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
//
// Read-side controller of an asynchronous FIFO. Keeps the binary read
// pointer, publishes its Gray-coded form to the write-side synchroniser and
// derives empty / almost-empty / occupancy from the write pointer that has
// already been synchronised into rclk. Read data from the dual-port RAM is
// registered into rdata. A sticky underflow flag records rejected reads.
//
// Build option:
//   FIFO_RD_FWFT_EN  when defined, the output register behaves as a
//                    first-word-fall-through stage: the next RAM word is
//                    loaded whenever the stage is empty (or is being drained),
//                    and rinc acts as consumer ready. When undefined, rinc is
//                    a plain pop request and rdata/rvalid follow it by one
//                    cycle.
//
// Parameters:
//   ADDR_SIZE   RAM address width (depth 2**ADDR_SIZE)
//   DATA_WIDTH  data word width
//   AE_THRESH   almost-empty threshold in words
//
// Ports:
//   rclk           read-domain clock
//   rrst           asynchronous active-high reset
//   rinc           read request / consumer ready
//   rq2_wptr       write pointer (Gray), synchronised into rclk
//   mem_rdata      RAM read data at raddr (combinational)
//   clr_underflow  clears the sticky underflow flag
//   raddr          RAM read address
//   rptr           read pointer (Gray), to the write-side synchroniser
//   rempty         RAM holds no unread word
//   ralmost_empty  occupancy <= AE_THRESH
//   rcount         RAM occupancy in words
//   rdata          registered read data
//   rvalid         rdata holds valid data
//   runderflow     sticky underflow error
// -----------------------------------------------------------------------------
module fifo_rd_ctrl #(
    parameter int ADDR_SIZE  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int AE_THRESH  = 1
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rinc,
    input  logic [ADDR_SIZE:0]    rq2_wptr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  clr_underflow,
    output logic [ADDR_SIZE-1:0]  raddr,
    output logic [ADDR_SIZE:0]    rptr,
    output logic                  rempty,
    output logic                  ralmost_empty,
    output logic [ADDR_SIZE:0]    rcount,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  runderflow
);

    localparam int          PW       = ADDR_SIZE + 1;
    localparam logic [31:0] AE_LIMIT = 32'(AE_THRESH);

    logic [PW-1:0]         rbin_q,  rbin_d;
    logic [PW-1:0]         rptr_q,  rptr_d;
    logic                  rempty_q, rempty_d;
    logic                  ralmost_empty_q, ralmost_empty_d;
    logic [PW-1:0]         rcount_q, rcount_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  runderflow_q, runderflow_d;

    logic                  pop;
    logic                  underflow_evt;
    logic [PW-1:0]         wbin;

    // Read strobe, output-stage valid and underflow condition per read mode.
    always_comb begin
        pop           = 1'b0;
        underflow_evt = 1'b0;
        rvalid_d      = rvalid_q;
`ifdef FIFO_RD_FWFT_EN
        // Refill the output stage whenever it is empty or being consumed.
        pop           = ~rempty_q & (~rvalid_q | rinc);
        underflow_evt = rinc & ~rvalid_q;
        if (pop) begin
            rvalid_d = 1'b1;
        end else if (rinc && rvalid_q) begin
            rvalid_d = 1'b0;
        end
`else
        pop           = rinc & ~rempty_q;
        underflow_evt = rinc & rempty_q;
        rvalid_d      = pop;
`endif
    end

    // Pointer arithmetic and status derived from the advanced pointer, so the
    // flags describe the state after this cycle's pop.
    always_comb begin
        rbin_d = rbin_q + {{ADDR_SIZE{1'b0}}, pop};
        rptr_d = rbin_d ^ (rbin_d >> 1);

        // Gray to binary: each bit is the XOR of all Gray bits at or above it.
        wbin = '0;
        for (int i = 0; i < PW; i++) begin
            wbin[i] = ^(rq2_wptr >> i);
        end

        rempty_d        = (rptr_d == rq2_wptr);
        rcount_d        = wbin - rbin_d;
        ralmost_empty_d = (32'(rcount_d) <= AE_LIMIT);

        rdata_d      = pop ? mem_rdata : rdata_q;
        // Set takes priority over a coincident clear.
        runderflow_d = underflow_evt | (runderflow_q & ~clr_underflow);
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            rbin_q          <= '0;
            rptr_q          <= '0;
            rempty_q        <= 1'b1;
            ralmost_empty_q <= 1'b1;
            rcount_q        <= '0;
            rdata_q         <= '0;
            rvalid_q        <= 1'b0;
            runderflow_q    <= 1'b0;
        end else begin
            rbin_q          <= rbin_d;
            rptr_q          <= rptr_d;
            rempty_q        <= rempty_d;
            ralmost_empty_q <= ralmost_empty_d;
            rcount_q        <= rcount_d;
            rdata_q         <= rdata_d;
            rvalid_q        <= rvalid_d;
            runderflow_q    <= runderflow_d;
        end
    end

    assign raddr         = rbin_q[ADDR_SIZE-1:0];
    assign rptr          = rptr_q;
    assign rempty        = rempty_q;
    assign ralmost_empty = ralmost_empty_q;
    assign rcount        = rcount_q;
    assign rdata         = rdata_q;
    assign rvalid        = rvalid_q;
    assign runderflow    = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

    logic       rclk = 1'b0;
    logic       rrst;
    logic       rinc;
    logic [3:0] rq2_wptr;
    logic [7:0] mem_rdata;
    logic       clr_underflow;
    logic [2:0] raddr;
    logic [3:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic [3:0] rcount;
    logic [7:0] rdata;
    logic       rvalid;
    logic       runderflow;

    logic [7:0] mem [8];

    int checks = 0;
    int errors = 0;

    fifo_rd_ctrl #(.ADDR_SIZE(3), .DATA_WIDTH(8), .AE_THRESH(1)) dut (
        .rclk(rclk), .rrst(rrst), .rinc(rinc), .rq2_wptr(rq2_wptr),
        .mem_rdata(mem_rdata), .clr_underflow(clr_underflow),
        .raddr(raddr), .rptr(rptr), .rempty(rempty),
        .ralmost_empty(ralmost_empty), .rcount(rcount), .rdata(rdata),
        .rvalid(rvalid), .runderflow(runderflow)
    );

    always #5 rclk = ~rclk;
    assign mem_rdata = mem[raddr];

    function automatic logic [3:0] gray4(input int v);
        logic [3:0] b;
        b = v[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 8; i++) mem[i] = 8'(8'hA0 + i);
    endtask

    task automatic test_reset();
        rrst = 1'b1; rinc = 1'b0; clr_underflow = 1'b0; rq2_wptr = 4'b0000;
        fill_mem();
        step(); step();
        rrst = 1'b0;
        step();
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b expected 1", rempty); end
        checks++; if (ralmost_empty !== 1'b1) begin errors++; $display("FAIL reset_ae: got %b expected 1", ralmost_empty); end
        checks++; if (rcount !== 4'd0) begin errors++; $display("FAIL reset_rcount: got %0d expected 0", rcount); end
        checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        checks++; if (rptr !== 4'd0 || raddr !== 3'd0) begin errors++; $display("FAIL reset_ptrs: got rptr=%b raddr=%0d expected 0/0", rptr, raddr); end
        checks++; if (rdata !== 8'h00 || runderflow !== 1'b0) begin errors++; $display("FAIL reset_data_uf: got rdata=%h uf=%b expected 00/0", rdata, runderflow); end
    endtask

    task automatic test_read3();
        rq2_wptr = 4'b0010;
        step();
        checks++; if (rcount !== 4'd3 || rempty !== 1'b0) begin errors++; $display("FAIL read3_pre: got rcount=%0d rempty=%b expected 3/0", rcount, rempty); end
        rinc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (rvalid !== 1'b1 || rdata !== 8'(8'hA0 + k)) begin errors++; $display("FAIL read3_word%0d: got rvalid=%b rdata=%h expected 1/%h", k, rvalid, rdata, 8'(8'hA0 + k)); end
        end
        rinc = 1'b0;
        checks++; if (rptr !== 4'b0010) begin errors++; $display("FAIL read3_rptr: got %b expected 0010", rptr); end
        checks++; if (rempty !== 1'b1 || rcount !== 4'd0) begin errors++; $display("FAIL read3_empty: got rempty=%b rcount=%0d expected 1/0", rempty, rcount); end
        step();
        checks++; if (rvalid !== 1'b0 || rdata !== 8'hA2) begin errors++; $display("FAIL read3_idle: got rvalid=%b rdata=%h expected 0/a2", rvalid, rdata); end
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", runderflow); end
        checks++; if (raddr !== 3'd3 || rptr !== 4'b0010 || rvalid !== 1'b0) begin errors++; $display("FAIL uf_no_advance: got raddr=%0d rptr=%b rvalid=%b expected 3/0010/0", raddr, rptr, rvalid); end
        step();
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", runderflow); end
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", runderflow); end
        rinc = 1'b1; clr_underflow = 1'b1;
        step();
        rinc = 1'b0; clr_underflow = 1'b0;
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL uf_set_wins: got %b expected 1", runderflow); end
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
        checks++; if (runderflow !== 1'b0) begin errors++; $display("FAIL uf_clear2: got %b expected 0", runderflow); end
    endtask

    task automatic test_count();
        // Asynchronous reset with a word held in rdata.
        rrst = 1'b1;
        #2;
        checks++; if (rdata !== 8'h00 || rvalid !== 1'b0 || rempty !== 1'b1) begin errors++; $display("FAIL async_reset: got rdata=%h rvalid=%b rempty=%b expected 00/0/1", rdata, rvalid, rempty); end
        rq2_wptr = 4'b0000;
        step();
        rrst = 1'b0;
        fill_mem();
        rq2_wptr = 4'b1100;
        step();
        checks++; if (rcount !== 4'd8 || rempty !== 1'b0 || ralmost_empty !== 1'b0) begin errors++; $display("FAIL count_full: got rcount=%0d rempty=%b ae=%b expected 8/0/0", rcount, rempty, ralmost_empty); end
        rinc = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            checks++; if (rcount !== 4'(8 - k) || ralmost_empty !== ((8 - k) <= 1) || rdata !== 8'(8'hA0 + k - 1)) begin
                errors++; $display("FAIL count_pop%0d: got rcount=%0d ae=%b rdata=%h expected %0d/%b/%h", k, rcount, ralmost_empty, rdata, 8 - k, ((8 - k) <= 1), 8'(8'hA0 + k - 1));
            end
        end
        rinc = 1'b0;
        checks++; if (rempty !== 1'b0) begin errors++; $display("FAIL count_one_left: got rempty=%b expected 0", rempty); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (rempty !== 1'b1 || rcount !== 4'd0 || rdata !== 8'hA7) begin errors++; $display("FAIL count_drained: got rempty=%b rcount=%0d rdata=%h expected 1/0/a7", rempty, rcount, rdata); end
    endtask

    task automatic test_wrap();
        int wr, rd;
        logic exp_empty, exp_pop;
        int exp_count;
        logic [7:0] exp_data;
        wr = 8; rd = 8; exp_empty = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if ((c % 4) != 3 && (wr - rd) < 8) begin
                mem[wr % 8] = 8'(wr * 7 + 3);
                wr++;
                rq2_wptr = gray4(wr);
            end
            rinc = ((c % 3) != 2);
            exp_pop = rinc && !exp_empty;
            exp_data = mem[rd % 8];
            step();
            if (exp_pop) rd++;
            exp_count = wr - rd;
            exp_empty = (exp_count == 0);
            checks++; if (rempty !== exp_empty || rcount !== 4'(exp_count) || ralmost_empty !== (exp_count <= 1)) begin
                errors++; $display("FAIL wrap_c%0d: got rempty=%b rcount=%0d ae=%b expected %b/%0d/%b", c, rempty, rcount, ralmost_empty, exp_empty, exp_count, (exp_count <= 1));
            end
            checks++; if (rvalid !== exp_pop || (exp_pop && rdata !== exp_data)) begin
                errors++; $display("FAIL wrap_data_c%0d: got rvalid=%b rdata=%h expected %b/%h", c, rvalid, rdata, exp_pop, exp_data);
            end
        end
        rinc = 1'b0;
        checks++; if (rptr !== gray4(rd) || rd < 16) begin errors++; $display("FAIL wrap_rptr: got %b expected %b (reads %0d)", rptr, gray4(rd), rd); end
        clr_underflow = 1'b1;
        step();
        clr_underflow = 1'b0;
    endtask

    task automatic test_fwft();
        rrst = 1'b1; rinc = 1'b0; rq2_wptr = 4'b0000;
        step();
        rrst = 1'b0;
        fill_mem();
        rq2_wptr = 4'b0001;
        step(); step();
        checks++; if (rvalid !== 1'b1 || rdata !== 8'hA0) begin errors++; $display("FAIL fwft_load: got rvalid=%b rdata=%h expected 1/a0", rvalid, rdata); end
        checks++; if (rempty !== 1'b1) begin errors++; $display("FAIL fwft_empty: got %b expected 1", rempty); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (rvalid !== 1'b0 || runderflow !== 1'b0) begin errors++; $display("FAIL fwft_consume: got rvalid=%b uf=%b expected 0/0", rvalid, runderflow); end
        rinc = 1'b1;
        step();
        rinc = 1'b0;
        checks++; if (runderflow !== 1'b1) begin errors++; $display("FAIL fwft_underflow: got %b expected 1", runderflow); end
    endtask

    initial begin
        test_reset();
`ifdef FIFO_RD_FWFT_EN
        test_fwft();
`else
        test_read3();
        test_underflow();
        test_count();
        test_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
